i2c_target: RTL and testbench

Write-only I2C target that is the receiving end of the team's two-byte I2C writer. It watches SCL/SDA, detects START/STOP, matches a 7-bit device address, ACKs the address and exactly two data bytes, and presents them as a register pair with a one-cycle valid strobe. It sits on the same `clk` domain as the writer so two-byte command traffic can be looped back on-chip and verified without external silicon.

---
 rtl/i2c_target.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// Write-only I2C target: matches a 7-bit address, ACKs two data bytes
// and publishes them as a register pair with a one-cycle valid strobe.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  output logic       data_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [3:0] {
    IDLE,
    ADDRESS,
    ADDR_ACK,
    DATA_0,
    ACK_0,
    DATA_1,
    ACK_1,
    HOLD,
    IGNORE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sh0_q, sh0_d;
  logic [7:0] sh1_q, sh1_d;
  logic [7:0] data0_q, data0_d;
  logic [7:0] data1_q, data1_d;
  logic       sda_low_q, sda_low_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;

  logic scl_m_q, scl_s_q, scl_p_q;
  logic sda_m_q, sda_s_q, sda_p_q;

  logic       start_ev, stop_ev;
  logic       scl_rise, scl_fall;
  logic [7:0] nxt_byte;

  // Lines idle high, so synchronizers reset to 1 to avoid false edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_m_q <= scl;
      scl_s_q <= scl_m_q;
      scl_p_q <= scl_s_q;
      sda_m_q <= sda;
      sda_s_q <= sda_m_q;
      sda_p_q <= sda_s_q;
    end
  end

  assign start_ev = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_ev  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
  assign scl_rise = scl_s_q & ~scl_p_q;
  assign scl_fall = ~scl_s_q & scl_p_q;
  assign nxt_byte = {shift_q[6:0], sda_s_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      sda_low_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      sda_low_q <= sda_low_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    sda_low_d = sda_low_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    ovr_d     = 1'b0;
    if (stop_ev) begin
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      state_d   = IDLE;
      if (state_q == HOLD) begin
        data0_d = sh0_q;
        data1_d = sh1_q;
        valid_d = 1'b1;
      end
    end else if (start_ev) begin
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      sh0_d     = '0;
      sh1_d     = '0;
      cnt_d     = '0;
      state_d   = ADDRESS;
    end else begin
      unique case (state_q)
        ADDRESS: begin
          if (scl_rise) begin
            shift_d = nxt_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (nxt_byte[7:1] == DEVICE_ADDRESS && !nxt_byte[0]) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK, ACK_0, ACK_1: begin
          // First fall ends the byte: pull; second fall ends the ACK clock
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = '0;
              state_d   = (state_q == ADDR_ACK) ? DATA_0 :
                          (state_q == ACK_0)    ? DATA_1 : HOLD;
            end
          end
        end
        DATA_0: begin
          if (scl_rise) begin
            shift_d = nxt_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              sh0_d   = nxt_byte;
              state_d = ACK_0;
            end
          end
        end
        DATA_1: begin
          if (scl_rise) begin
            shift_d = nxt_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              sh1_d   = nxt_byte;
              state_d = ACK_1;
            end
          end
        end
        HOLD: begin
          // Nine clocks per extra byte: eight data plus the NACK clock
          if (scl_rise) begin
            cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
            if (cnt_q == 4'd7) ovr_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda        = sda_low_q ? 1'b0 : 1'bz;
  assign data_0     = data0_q;
  assign data_1     = data1_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C writer plus a transaction-level
// model of what the target should ACK, count and publish.
module tb_i2c_target;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] data_0, data_1;
  logic       data_valid, busy, overrun;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_target #(.DEVICE_ADDRESS(7'h39)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_valid(data_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ovr_cnt = 0;
  int busy_cyc = 0;
  int tgt_low = 0;
  logic [7:0] exp_d0 = 8'h00;
  logic [7:0] exp_d1 = 8'h00;

  always @(negedge clk) begin
    if (data_valid === 1'b1) valid_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (sda === 1'b0 && !m_low) tgt_low++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_cyc(T);
    scl = 1'b1;   wait_cyc(T);
    m_low = 1'b1; wait_cyc(T);
    scl = 1'b0;   wait_cyc(T);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_cyc(T);
    scl = 1'b1;   wait_cyc(T);
    m_low = 1'b0; wait_cyc(3 * T);
  endtask

  task automatic send_bits(input logic [7:0] b, output int stray);
    stray = 0;
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; wait_cyc(T);
      scl = 1'b1;    wait_cyc(T / 2);
      @(negedge clk);
      if (sda !== b[i]) stray++;
      wait_cyc(T / 2);
      scl = 1'b0;    wait_cyc(T);
    end
  endtask

  task automatic ack_clock(output logic a);
    m_low = 1'b0; wait_cyc(T);
    scl = 1'b1;   wait_cyc(T / 2);
    @(negedge clk);
    a = sda;
    wait_cyc(T / 2);
    scl = 1'b0;   wait_cyc(T);
  endtask

  // acked[0] = address ACK, acked[i+1] = data byte i ACK
  task automatic do_xfer(input logic [7:0] ab, input int n,
                         input logic [31:0] bytes,
                         output logic [3:0] acked, output int stray);
    logic a;
    int   s;
    acked = '0;
    stray = 0;
    i2c_start();
    send_bits(ab, s); stray += s;
    ack_clock(a); acked[0] = ~a;
    for (int i = 0; i < n; i++) begin
      send_bits(bytes[8*i +: 8], s); stray += s;
      ack_clock(a); acked[i+1] = ~a;
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    wait_cyc(4);
    @(negedge clk);
    checks++;
    if (data_0 !== 8'h00 || data_1 !== 8'h00 || data_valid !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0 || sda !== 1'b1) begin
      errors++;
      $display("FAIL reset: d0=%h d1=%h v=%b b=%b o=%b sda=%b want 00 00 0 0 0 1",
               data_0, data_1, data_valid, busy, overrun, sda);
    end
    rst = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int   s0, s1, s2;
    int   v0;
    v0 = valid_cnt;
    i2c_start();
    send_bits(8'h72, s0); ack_clock(a0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL write_busy: got %b want 1", busy);
    end
    send_bits(8'hA5, s1); ack_clock(a1);
    send_bits(8'h3C, s2); ack_clock(a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b000 || s0 + s1 + s2 != 0) begin
      errors++;
      $display("FAIL write_ack: acks=%b stray=%0d want 000 0", {a0, a1, a2}, s0 + s1 + s2);
    end
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++; $display("FAIL write_valid: pulses=%0d want 1", valid_cnt - v0);
    end
    exp_d0 = 8'hA5; exp_d1 = 8'h3C;
    checks++;
    if (data_0 !== exp_d0 || data_1 !== exp_d1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_data: d0=%h d1=%h busy=%b want %h %h 0", data_0, data_1, busy, exp_d0, exp_d1);
    end
  endtask

  task automatic test_no_match(input logic [7:0] ab, input string nm);
    logic [3:0] ack;
    int st, v0, b0, t0;
    v0 = valid_cnt; b0 = busy_cyc; t0 = tgt_low;
    do_xfer(ab, 2, 32'h00002211, ack, st);
    checks++;
    if (ack !== 4'b0000 || tgt_low != t0 || st != 0) begin
      errors++;
      $display("FAIL %s_drive: acked=%b low_cycles=%0d stray=%0d want 0000 0 0", nm, ack, tgt_low - t0, st);
    end
    checks++;
    if (busy_cyc != b0 || valid_cnt != v0) begin
      errors++;
      $display("FAIL %s_flags: busy_cyc=%0d valid=%0d want 0 0", nm, busy_cyc - b0, valid_cnt - v0);
    end
    checks++;
    if (data_0 !== exp_d0 || data_1 !== exp_d1) begin
      errors++;
      $display("FAIL %s_data: d0=%h d1=%h want %h %h", nm, data_0, data_1, exp_d0, exp_d1);
    end
  endtask

  task automatic test_short();
    logic [3:0] ack;
    int st, v0;
    v0 = valid_cnt;
    do_xfer(8'h72, 1, 32'h00000055, ack, st);
    checks++;
    if (ack !== 4'b0011 || valid_cnt != v0) begin
      errors++;
      $display("FAIL short: acked=%b valid=%0d want 0011 0", ack, valid_cnt - v0);
    end
    checks++;
    if (data_0 !== exp_d0 || data_1 !== exp_d1) begin
      errors++;
      $display("FAIL short_data: d0=%h d1=%h want %h %h", data_0, data_1, exp_d0, exp_d1);
    end
  endtask

  task automatic test_overrun();
    logic [3:0] ack;
    int st, v0, o0;
    v0 = valid_cnt; o0 = ovr_cnt;
    do_xfer(8'h72, 3, 32'h00030201, ack, st);
    exp_d0 = 8'h01; exp_d1 = 8'h02;
    checks++;
    if (ack !== 4'b0111 || st != 0) begin
      errors++; $display("FAIL overrun_ack: acked=%b stray=%0d want 0111 0", ack, st);
    end
    checks++;
    if (ovr_cnt - o0 != 1 || valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL overrun_pulses: ovr=%0d valid=%0d want 1 1", ovr_cnt - o0, valid_cnt - v0);
    end
    checks++;
    if (data_0 !== exp_d0 || data_1 !== exp_d1) begin
      errors++;
      $display("FAIL overrun_data: d0=%h d1=%h want %h %h", data_0, data_1, exp_d0, exp_d1);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [3:0] ack;
    int s, st, v0;
    i2c_start();
    send_bits(8'h72, s); ack_clock(a);
    send_bits(8'h77, s);
    m_low = 1'b0; wait_cyc(T);
    scl = 1'b1;   wait_cyc(2);
    @(negedge clk);
    checks++;
    if (sda !== 1'b0) begin
      errors++; $display("FAIL mid_ack0_pull: sda=%b want 0", sda);
    end
    rst = 1'b0;
    #1;
    exp_d0 = 8'h00; exp_d1 = 8'h00;
    checks++;
    if (sda !== 1'b1 || data_0 !== 8'h00 || data_1 !== 8'h00 ||
        busy !== 1'b0 || data_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sda=%b d0=%h d1=%h b=%b v=%b o=%b want 1 00 00 0 0 0",
               sda, data_0, data_1, busy, data_valid, overrun);
    end
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(T);
    scl = 1'b0; wait_cyc(T);
    i2c_stop();
    v0 = valid_cnt;
    do_xfer(8'h72, 2, 32'h00008877, ack, st);
    exp_d0 = 8'h77; exp_d1 = 8'h88;
    checks++;
    if (ack !== 4'b0111 || valid_cnt - v0 != 1 ||
        data_0 !== exp_d0 || data_1 !== exp_d1) begin
      errors++;
      $display("FAIL mid_recover: acked=%b valid=%0d d0=%h d1=%h want 0111 1 %h %h",
               ack, valid_cnt - v0, data_0, data_1, exp_d0, exp_d1);
    end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2, a3, a4, a5;
    int s, v0;
    v0 = valid_cnt;
    i2c_start();
    send_bits(8'h72, s); ack_clock(a0);
    send_bits(8'hAA, s); ack_clock(a1);
    send_bits(8'hBB, s); ack_clock(a2);
    i2c_start();
    send_bits(8'h72, s); ack_clock(a3);
    send_bits(8'h10, s); ack_clock(a4);
    send_bits(8'h20, s); ack_clock(a5);
    i2c_stop();
    exp_d0 = 8'h10; exp_d1 = 8'h20;
    checks++;
    if ({a0, a1, a2, a3, a4, a5} !== 6'b000000) begin
      errors++; $display("FAIL rstart_ack: acks=%b want 000000", {a0, a1, a2, a3, a4, a5});
    end
    checks++;
    if (valid_cnt - v0 != 1 || data_0 !== exp_d0 || data_1 !== exp_d1) begin
      errors++;
      $display("FAIL rstart_data: valid=%0d d0=%h d1=%h want 1 %h %h",
               valid_cnt - v0, data_0, data_1, exp_d0, exp_d1);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ab;
    logic [31:0] bytes;
    logic [3:0]  ack, exp_ack;
    logic        match;
    int n, st, v0, o0, b0, exp_ovr, exp_v;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) != 0)
        ab = {7'h39, ($urandom_range(0, 3) == 0)};
      else
        ab = 8'($urandom_range(0, 255));
      n     = $urandom_range(0, 3);
      bytes = $urandom;
      v0 = valid_cnt; o0 = ovr_cnt; b0 = busy_cyc;
      do_xfer(ab, n, bytes, ack, st);
      match   = (ab[7:1] == 7'h39) && !ab[0];
      exp_ack = '0;
      if (match) begin
        exp_ack[0] = 1'b1;
        for (int i = 0; i < n && i < 2; i++) exp_ack[i+1] = 1'b1;
      end
      exp_ovr = (match && n > 2) ? n - 2 : 0;
      exp_v   = (match && n >= 2) ? 1 : 0;
      if (exp_v == 1) begin
        exp_d0 = bytes[7:0];
        exp_d1 = bytes[15:8];
      end
      checks++;
      if (ack !== exp_ack || st != 0) begin
        errors++;
        $display("FAIL rand%0d_ack: addr=%h n=%0d acked=%b stray=%0d want %b 0",
                 k, ab, n, ack, st, exp_ack);
      end
      checks++;
      if (valid_cnt - v0 != exp_v || ovr_cnt - o0 != exp_ovr ||
          (busy_cyc != b0) != match) begin
        errors++;
        $display("FAIL rand%0d_flags: valid=%0d ovr=%0d busy_seen=%b want %0d %0d %b",
                 k, valid_cnt - v0, ovr_cnt - o0, busy_cyc != b0, exp_v, exp_ovr, match);
      end
      checks++;
      if (data_0 !== exp_d0 || data_1 !== exp_d1) begin
        errors++;
        $display("FAIL rand%0d_data: d0=%h d1=%h want %h %h", k, data_0, data_1, exp_d0, exp_d1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_no_match(8'h74, "wrong_addr");
    test_no_match(8'h73, "read_bit");
    test_short();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
